// File: rtl/uart_baud_tick_gen.sv
// Programmable oversampling baud tick generator: oversample, mid-bit and
// bit-boundary strobes from a runtime-loadable divisor, with start-edge resync.
module uart_baud_tick_gen #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 20,
  parameter int OVS         = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 div_load,
  input  logic                 resync,
  output logic                 os_tick,
  output logic                 bit_tick,
  output logic                 mid_tick,
  output logic [DIV_WIDTH-1:0] div_cur
);

  localparam int PH_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [PH_W-1:0]      PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0]      PH_MID  = PH_W'(OVS / 2);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] cnt;
  logic [PH_W-1:0]      phase;
  logic [PH_W-1:0]      ph_nxt;
  logic                 load_ok;
  logic [DIV_WIDTH-1:0] resync_div;

  assign load_ok    = div_load && (div_in != '0);
  // A resync coinciding with a valid load restarts on the new divisor.
  assign resync_div = load_ok ? div_in : div_reg;
  assign ph_nxt     = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
  assign div_cur    = div_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_reg  <= DIV_WIDTH'(DEFAULT_DIV);
      cnt      <= DIV_WIDTH'(DEFAULT_DIV - 1);
      phase    <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
      if (load_ok)
        div_reg <= div_in;
      if (resync) begin
        cnt   <= resync_div - ONE;
        phase <= '0;
      end else if (en) begin
        if (cnt != '0) begin
          cnt <= cnt - ONE;
        end else begin
          // Reload uses the divisor held before this edge's load.
          cnt      <= div_reg - ONE;
          phase    <= ph_nxt;
          os_tick  <= 1'b1;
          bit_tick <= (ph_nxt == '0);
          mid_tick <= (ph_nxt == PH_MID);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Directed bench for uart_baud_tick_gen: records the edge numbers of each
// strobe and compares them against hand-computed schedules.
module tb_uart_baud_tick_gen;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_in = '0;
  logic        div_load = 1'b0;
  logic        resync = 1'b0;
  logic        os_tick, bit_tick, mid_tick;
  logic [15:0] div_cur;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int both_hi = 0;
  int os_q[$];
  int mid_q[$];
  int bit_q[$];

  uart_baud_tick_gen #(.DIV_WIDTH(16), .DEFAULT_DIV(20), .OVS(16)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .resync(resync), .os_tick(os_tick), .bit_tick(bit_tick), .mid_tick(mid_tick),
    .div_cur(div_cur)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Advance n edges; outputs are sampled 1ns after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      edge_n++;
      if (os_tick)  os_q.push_back(edge_n);
      if (mid_tick) mid_q.push_back(edge_n);
      if (bit_tick) bit_q.push_back(edge_n);
      if (bit_tick && mid_tick) both_hi++;
    end
  endtask

  task automatic clr();
    os_q.delete();
    mid_q.delete();
    bit_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; div_load = 1'b0; resync = 1'b0; div_in = '0;
    run(2);
    chk("rst_os", int'(os_tick), 0);
    chk("rst_bit_mid", int'(bit_tick | mid_tick), 0);
    chk("rst_div_cur", int'(div_cur), 20);
    rst = 1'b0;
    edge_n = 0;
    clr();
  endtask

  initial begin
    // Defaults: div 20, OVS 16
    do_reset();
    en = 1'b1;
    run(320);
    chk("def_os0", q_at(os_q, 0), 20);
    chk("def_os1", q_at(os_q, 1), 40);
    chk("def_os2", q_at(os_q, 2), 60);
    chk("def_os_cnt", os_q.size(), 16);
    chk("def_mid", q_at(mid_q, 0), 160);
    chk("def_mid_cnt", mid_q.size(), 1);
    chk("def_bit", q_at(bit_q, 0), 320);
    chk("def_bit_cnt", bit_q.size(), 1);
    chk("def_div_cur", int'(div_cur), 20);

    // Load 4 at edge 5: current period completes at 20
    do_reset();
    en = 1'b1;
    run(4);
    div_in = 16'd4; div_load = 1'b1;
    run(1);
    div_load = 1'b0;
    chk("ld4_div_cur", int'(div_cur), 4);
    run(27);
    chk("ld4_os_cnt", os_q.size(), 4);
    chk("ld4_os0", q_at(os_q, 0), 20);
    chk("ld4_os1", q_at(os_q, 1), 24);
    chk("ld4_os3", q_at(os_q, 3), 32);

    // Load 0 ignored, then load 1
    clr();
    div_in = 16'd0; div_load = 1'b1;
    run(1);
    div_load = 1'b0;
    chk("ld0_div_cur", int'(div_cur), 4);
    run(7);
    chk("ld0_os_cnt", os_q.size(), 2);
    chk("ld0_os0", q_at(os_q, 0), 36);
    chk("ld0_os1", q_at(os_q, 1), 40);
    clr();
    div_in = 16'd1; div_load = 1'b1;
    run(1);
    div_load = 1'b0;
    chk("ld1_div_cur", int'(div_cur), 1);
    run(7);
    chk("ld1_os_cnt", os_q.size(), 5);
    chk("ld1_os0", q_at(os_q, 0), 44);
    chk("ld1_os4", q_at(os_q, 4), 48);

    // div 4 set by load+resync together, then resync one edge before a due tick
    do_reset();
    div_in = 16'd4; div_load = 1'b1; resync = 1'b1;
    run(1);
    div_load = 1'b0; resync = 1'b0; en = 1'b1;
    chk("rs_div_cur", int'(div_cur), 4);
    edge_n = 0;
    clr();
    run(14);
    chk("rs_pre_os2", q_at(os_q, 2), 12);
    clr();
    resync = 1'b1;
    run(1);
    resync = 1'b0;
    run(35);
    chk("rs_os_cnt", os_q.size(), 8);
    chk("rs_os0", q_at(os_q, 0), 19);
    chk("rs_mid", q_at(mid_q, 0), 47);
    chk("rs_mid_cnt", mid_q.size(), 1);

    // en low for 3 cycles mid-period
    run(2);
    clr();
    en = 1'b0;
    run(3);
    chk("en_off_os_cnt", os_q.size(), 0);
    en = 1'b1;
    run(27);
    chk("en_os0", q_at(os_q, 0), 58);
    chk("en_os_cnt", os_q.size(), 7);
    chk("en_bit", q_at(bit_q, 0), 82);
    chk("en_mid_cnt", mid_q.size(), 0);

    // Reset on a due-tick edge with phase 11; rst beats resync/load
    do_reset();
    en = 1'b1;
    run(239);
    chk("mr_os_cnt_pre", os_q.size(), 11);
    rst = 1'b1; div_in = 16'd7; div_load = 1'b1; resync = 1'b1;
    run(1);
    chk("mr_os", int'(os_tick), 0);
    chk("mr_bit_mid", int'(bit_tick | mid_tick), 0);
    chk("mr_div_cur", int'(div_cur), 20);
    rst = 1'b0; div_load = 1'b0; resync = 1'b0;
    edge_n = 0;
    clr();
    run(160);
    chk("mr_os0", q_at(os_q, 0), 20);
    chk("mr_os_cnt", os_q.size(), 8);
    chk("mr_mid", q_at(mid_q, 0), 160);

    chk("bit_mid_overlap", both_hi, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
